// File: rtl/serial_auth_setter.sv
// Setter side of the serial authenticator: holds the enrolled secret, checks a
// guess one bit per handshake (MSB first) and enforces a timed lockout.
module serial_auth_setter #(
   parameter int WIDTH       = 8,
   parameter int MAX_FAILS   = 3,
   parameter int LOCK_CYCLES = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     set_valid,
   input  logic [WIDTH-1:0]         set_code,
   input  logic                     guess_valid,
   input  logic                     guess_bit,
   output logic                     guess_ready,
   output logic                     setter_bit,
   output logic [$clog2(WIDTH)-1:0] bit_idx,
   output logic                     matched,
   output logic                     unmatched,
   output logic                     armed,
   output logic                     locked
);

   localparam int IW = $clog2(WIDTH);
   localparam int FW = $clog2(MAX_FAILS + 1);
   localparam int TW = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;

   localparam logic [IW-1:0] LAST_IDX   = IW'(WIDTH - 1);
   localparam logic [FW-1:0] FAIL_LIMIT = FW'(MAX_FAILS);
   localparam logic [TW-1:0] LOCK_LOAD  = TW'(LOCK_CYCLES - 1);

   typedef enum logic [1:0] {S_IDLE, S_ARMED, S_RECV, S_LOCKED} state_t;

   state_t           state;
   logic [WIDTH-1:0] code;
   logic             mismatch;
   logic [FW-1:0]    fail_cnt;
   logic [TW-1:0]    timer;

   logic          accept;
   logic          bit_err;
   logic          final_err;
   logic [FW-1:0] fail_next;

   assign setter_bit = code[LAST_IDX - bit_idx];

   always_comb begin
      accept    = guess_valid && guess_ready;
      bit_err   = guess_bit ^ setter_bit;
      final_err = mismatch | bit_err;
      fail_next = (fail_cnt == FAIL_LIMIT) ? fail_cnt : fail_cnt + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= S_IDLE;
         code        <= '0;
         bit_idx     <= '0;
         mismatch    <= 1'b0;
         fail_cnt    <= '0;
         timer       <= '0;
         guess_ready <= 1'b0;
         matched     <= 1'b0;
         unmatched   <= 1'b0;
         armed       <= 1'b0;
         locked      <= 1'b0;
      end else begin
         matched   <= 1'b0;
         unmatched <= 1'b0;
         case (state)
            S_IDLE: begin
               if (set_valid) begin
                  code        <= set_code;
                  fail_cnt    <= '0;
                  state       <= S_ARMED;
                  guess_ready <= 1'b1;
                  armed       <= 1'b1;
               end
            end
            S_ARMED: begin
               // Enrollment takes priority; a bit offered in the same cycle is dropped.
               if (set_valid) begin
                  code     <= set_code;
                  fail_cnt <= '0;
               end else if (accept) begin
                  mismatch <= bit_err;
                  bit_idx  <= IW'(1);
                  state    <= S_RECV;
               end
            end
            S_RECV: begin
               if (accept) begin
                  if (bit_idx == LAST_IDX) begin
                     bit_idx  <= '0;
                     mismatch <= 1'b0;
                     if (!final_err) begin
                        matched  <= 1'b1;
                        fail_cnt <= '0;
                        state    <= S_ARMED;
                     end else begin
                        unmatched <= 1'b1;
                        fail_cnt  <= fail_next;
                        if (fail_next == FAIL_LIMIT) begin
                           state       <= S_LOCKED;
                           timer       <= LOCK_LOAD;
                           locked      <= 1'b1;
                           armed       <= 1'b0;
                           guess_ready <= 1'b0;
                        end else begin
                           state <= S_ARMED;
                        end
                     end
                  end else begin
                     mismatch <= final_err;
                     bit_idx  <= bit_idx + 1'b1;
                  end
               end
            end
            S_LOCKED: begin
               // Timer is preloaded with LOCK_CYCLES-1 so locked spans exactly LOCK_CYCLES cycles.
               if (timer == '0) begin
                  state       <= S_ARMED;
                  fail_cnt    <= '0;
                  locked      <= 1'b0;
                  armed       <= 1'b1;
                  guess_ready <= 1'b1;
               end else begin
                  timer <= timer - 1'b1;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
